// File: rtl/imm_ext_pipe.sv
// Immediate generator for the RV datapath: decodes instruction bits [31:7] into an
// XLEN-wide immediate behind a 2-entry valid/ready elastic buffer (output reg + skid reg).
module imm_ext_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [24:0]     imm_in,
  input  logic [2:0]      imm_src,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_err,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [2:0] SRC_I     = 3'd0;
  localparam logic [2:0] SRC_S     = 3'd1;
  localparam logic [2:0] SRC_B     = 3'd2;
  localparam logic [2:0] SRC_J     = 3'd3;
  localparam logic [2:0] SRC_U     = 3'd4;
  localparam logic [2:0] SRC_Z     = 3'd5;
  localparam logic [2:0] SRC_SHAMT = 3'd6;

  logic            or_valid_q, or_valid_d;
  logic [XLEN-1:0] or_data_q, or_data_d;
  logic            or_err_q, or_err_d;
  logic            sk_valid_q, sk_valid_d;
  logic [XLEN-1:0] sk_data_q, sk_data_d;
  logic            sk_err_q, sk_err_d;
  logic            in_ready_q, in_ready_d;

  logic            sgn_c;
  logic [31:0]     imm32_c;
  logic [XLEN-1:0] ext_c;
  logic            err_c;
  logic            accept_c;
  logic            consume_c;

  // Formats I/S/B/J/U are built as 32-bit values (sign at bit 31) then sign-extended.
  always_comb begin
    sgn_c   = imm_in[24];
    imm32_c = 32'd0;
    ext_c   = '0;
    err_c   = 1'b0;
    unique case (imm_src)
      SRC_I: imm32_c = {{20{sgn_c}}, imm_in[24:13]};
      SRC_S: imm32_c = {{20{sgn_c}}, imm_in[24:18], imm_in[4:0]};
      SRC_B: imm32_c = {{20{sgn_c}}, imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0};
      SRC_J: imm32_c = {{12{sgn_c}}, imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0};
      SRC_U: imm32_c = {imm_in[24:5], 12'd0};
      default: imm32_c = 32'd0;
    endcase
    if (imm_src == SRC_Z) begin
      ext_c = XLEN'(imm_in[12:8]);
    end else if (imm_src == SRC_SHAMT) begin
      ext_c = XLEN'(imm_in[SHAMT_W+12:13]);
    end else if (imm_src == 3'd7) begin
      err_c = 1'b1;
    end else begin
      ext_c = XLEN'($signed(imm32_c));
    end
  end

  assign accept_c  = in_valid && in_ready_q;
  assign consume_c = or_valid_q && out_ready;

  // Next-state for the output/skid pair; accept never coincides with a full skid.
  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_err_d   = or_err_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_err_d   = sk_err_q;
    if (consume_c) begin
      if (sk_valid_q) begin
        or_data_d  = sk_data_q;
        or_err_d   = sk_err_q;
        sk_valid_d = 1'b0;
      end else begin
        or_valid_d = 1'b0;
      end
    end
    if (accept_c) begin
      if (!or_valid_q || consume_c) begin
        or_valid_d = 1'b1;
        or_data_d  = ext_c;
        or_err_d   = err_c;
      end else begin
        sk_valid_d = 1'b1;
        sk_data_d  = ext_c;
        sk_err_d   = err_c;
      end
    end
    in_ready_d = !sk_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_err_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_err_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_err_q   <= or_err_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_err_q   <= sk_err_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign imm_out   = or_data_q;
  assign imm_err   = or_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: RV32 and RV64 instances driven from shared inputs.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] imm_in;
  logic [2:0]  imm_src;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm_out32;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_out64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .SHAMT_W(5)) u32 (
    .clk(clk), .rst(rst), .imm_in(imm_in), .imm_src(imm_src),
    .in_valid(in_valid), .in_ready(in_ready32), .imm_out(imm_out32),
    .imm_err(imm_err32), .out_valid(out_valid32), .out_ready(out_ready)
  );

  imm_ext_pipe #(.XLEN(64), .SHAMT_W(6)) u64 (
    .clk(clk), .rst(rst), .imm_in(imm_in), .imm_src(imm_src),
    .in_valid(in_valid), .in_ready(in_ready64), .imm_out(imm_out64),
    .imm_err(imm_err64), .out_valid(out_valid64), .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [2:0] src);
    imm_in   = inst[31:7];
    imm_src  = src;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; imm_in = '0; imm_src = 3'd0;
    step(); step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid32); end
    total++; if (imm_out32 !== 32'h0) begin bad++; $display("FAIL reset_imm_out got=%h exp=0", imm_out32); end
    total++; if (imm_err32 !== 1'b0) begin bad++; $display("FAIL reset_imm_err got=%b exp=0", imm_err32); end
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready32); end
    rst = 1'b0;
  endtask

  task automatic test_i_type();
    imm_in = {12'hFFF, 13'h0}; imm_src = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1) begin bad++; $display("FAIL i_valid got=%b exp=1", out_valid32); end
    total++; if (imm_out32 !== 32'hFFFFFFFF) begin bad++; $display("FAIL i_value got=%h exp=ffffffff", imm_out32); end
    total++; if (imm_err32 !== 1'b0) begin bad++; $display("FAIL i_err got=%b exp=0", imm_err32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL i_drain got=%b exp=0", out_valid32); end
  endtask

  task automatic test_b_j_u();
    out_ready = 1'b1;
    drive(32'hFE000EE3, 3'd2); step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'hFFFFFFFC) begin bad++; $display("FAIL b_type got=%b/%h exp=1/fffffffc", out_valid32, imm_out32); end
    drive(32'hFFDFF06F, 3'd3); step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'hFFFFFFFC) begin bad++; $display("FAIL j_type got=%b/%h exp=1/fffffffc", out_valid32, imm_out32); end
    drive(32'h800002B7, 3'd4); step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'h80000000) begin bad++; $display("FAIL u_type got=%b/%h exp=1/80000000", out_valid32, imm_out32); end
    drive(32'h80F00023, 3'd1); step();
    // sw with S-imm = {1000000, 00000} -> -2048
    total++; if (imm_out32 !== 32'hFFFFF800) begin bad++; $display("FAIL s_type got=%h exp=fffff800", imm_out32); end
    in_valid = 1'b0; step();
  endtask

  task automatic test_xlen64();
    out_ready = 1'b1;
    imm_in = 25'h3F << 13; imm_src = 3'd6; in_valid = 1'b1; step();
    total++; if (imm_out64 !== 64'h3F) begin bad++; $display("FAIL shamt64 got=%h exp=3f", imm_out64); end
    total++; if (imm_out32 !== 32'h1F) begin bad++; $display("FAIL shamt32 got=%h exp=1f", imm_out32); end
    imm_in = 25'h1F << 8; imm_src = 3'd5; step();
    total++; if (imm_out64 !== 64'h1F) begin bad++; $display("FAIL zimm64 got=%h exp=1f", imm_out64); end
    imm_in = 25'h1000000; imm_src = 3'd4; step();
    total++; if (imm_out64 !== 64'hFFFFFFFF80000000) begin bad++; $display("FAIL u64 got=%h exp=ffffffff80000000", imm_out64); end
    imm_in = {12'hFFF, 13'h0}; imm_src = 3'd0; step();
    total++; if (imm_out64 !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL i64 got=%h exp=all ones", imm_out64); end
    in_valid = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    imm_in = 25'h1 << 13; imm_src = 3'd0; in_valid = 1'b1; step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'h1 || in_ready32 !== 1'b1) begin bad++; $display("FAIL bp_first got=%b/%h/%b exp=1/1/1", out_valid32, imm_out32, in_ready32); end
    imm_in = 25'h2 << 13; step();
    in_valid = 1'b0;
    total++; if (imm_out32 !== 32'h1 || in_ready32 !== 1'b0) begin bad++; $display("FAIL bp_full got=%h/%b exp=1/0", imm_out32, in_ready32); end
    step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'h1 || in_ready32 !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b/%h/%b exp=1/1/0", out_valid32, imm_out32, in_ready32); end
    out_ready = 1'b1; step();
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'h2 || in_ready32 !== 1'b1) begin bad++; $display("FAIL bp_second got=%b/%h/%b exp=1/2/1", out_valid32, imm_out32, in_ready32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid32); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    imm_in = '1; imm_src = 3'd7; in_valid = 1'b1; step();
    total++; if (imm_out32 !== 32'h0 || imm_err32 !== 1'b1) begin bad++; $display("FAIL illegal got=%h/%b exp=0/1", imm_out32, imm_err32); end
    imm_in = 25'h123 << 13; imm_src = 3'd0; step();
    in_valid = 1'b0;
    total++; if (imm_out32 !== 32'h123 || imm_err32 !== 1'b0) begin bad++; $display("FAIL after_illegal got=%h/%b exp=123/0", imm_out32, imm_err32); end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    imm_in = 25'h5 << 13; imm_src = 3'd0; in_valid = 1'b1; step();
    imm_in = 25'h6 << 13; step();
    in_valid = 1'b0;
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL ar_full got=%b exp=0", in_ready32); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin bad++; $display("FAIL ar_immediate got=%b/%b exp=0/1", out_valid32, in_ready32); end
    total++; if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin bad++; $display("FAIL ar_immediate64 got=%b/%b exp=0/1", out_valid64, in_ready64); end
    rst = 1'b0;
    out_ready = 1'b1;
    imm_in = 25'h7 << 13; in_valid = 1'b1; step();
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1 || imm_out32 !== 32'h7) begin bad++; $display("FAIL ar_first got=%b/%h exp=1/7", out_valid32, imm_out32); end
    step();
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL ar_drain got=%b exp=0", out_valid32); end
  endtask

  initial begin
    test_reset();
    test_i_type();
    test_b_j_u();
    test_xlen64();
    test_back_to_back();
    test_illegal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
